// File: rtl/riscv_soc_top.sv
// rtl/riscv_soc_top.sv - single-cycle RV32I core with writable ROM and RAM on one shared bus
//
// Purpose: one instruction retires per rising clk edge. Fetch, decode, ALU,
// data-memory read and load lane select are all combinational within the cycle.
// Register write, memory write and PC update land together on the clock edge.
//
// Ports:
//   clk             in  system clock, all state updates on its rising edge
//   sys_rst_n       in  asynchronous active-low reset (PC and x1..x31 cleared, memories kept)
//   uart_debug_pin  in  run enable: 1 = execute, 0 = hold PC, registers and memories
//
// Hierarchy: u_rom._rom and u_ram._ram are the word arrays reached hierarchically
// by the compliance flow for preload and signature dump.

module riscv_soc_top #(
  parameter int ROM_DEPTH = 4096,
  parameter int RAM_DEPTH = 4096
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic uart_debug_pin
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  logic        run;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] regs_q [0:31];

  logic [31:0] instr, rom_fetch, rom_rdata, ram_rdata;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, op_b, alu_y;
  logic        br_take;

  logic [31:0] dm_addr, dm_rdata, dm_wdata, ld_data;
  logic [3:0]  dm_strb;
  logic        dm_we, rom_we, ram_we;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic        rf_we;
  logic [31:0] rf_wdata;

  assign run      = uart_debug_pin;
  assign pc_plus4 = pc_q + 32'd4;

  // Fetch outside the ROM region yields 0, which decodes as a NOP.
  assign instr = (pc_q[31:28] == 4'h0) ? rom_fetch : 32'h0;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_v = (rs1 == 5'd0) ? 32'h0 : regs_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'h0 : regs_q[rs2];

  // OP-IMM shifts take shamt from imm[4:0]; instr[30] selects SUB (OP only) and SRA/SRAI.
  assign op_b = (opcode == OPC_OP) ? rs2_v : imm_i;

  always_comb begin
    alu_y = 32'h0;
    case (funct3)
      3'b000: alu_y = ((opcode == OPC_OP) && instr[30]) ? rs1_v - op_b : rs1_v + op_b;
      3'b001: alu_y = rs1_v << op_b[4:0];
      3'b010: alu_y = {31'h0, $signed(rs1_v) < $signed(op_b)};
      3'b011: alu_y = {31'h0, rs1_v < op_b};
      3'b100: alu_y = rs1_v ^ op_b;
      3'b101: alu_y = instr[30] ? $unsigned($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
      3'b110: alu_y = rs1_v | op_b;
      3'b111: alu_y = rs1_v & op_b;
      default: alu_y = 32'h0;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000: br_take = (rs1_v == rs2_v);
      3'b001: br_take = (rs1_v != rs2_v);
      3'b100: br_take = ($signed(rs1_v) < $signed(rs2_v));
      3'b101: br_take = ($signed(rs1_v) >= $signed(rs2_v));
      3'b110: br_take = (rs1_v < rs2_v);
      3'b111: br_take = (rs1_v >= rs2_v);
      default: br_take = 1'b0;
    endcase
  end

  // Shared data bus: region decode on addr[31:28].
  assign dm_addr = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);

  always_comb begin
    case (dm_addr[31:28])
      4'h0:    dm_rdata = rom_rdata;
      4'h1:    dm_rdata = ram_rdata;
      default: dm_rdata = 32'h0;
    endcase
  end

  // Store lanes: data replicated across lanes, strobes pick the target bytes.
  always_comb begin
    dm_strb  = 4'b0000;
    dm_wdata = rs2_v;
    case (funct3)
      3'b000: begin
        dm_strb  = 4'b0001 << dm_addr[1:0];
        dm_wdata = {4{rs2_v[7:0]}};
      end
      3'b001: begin
        dm_strb  = dm_addr[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{rs2_v[15:0]}};
      end
      3'b010:  dm_strb = 4'b1111;
      default: dm_strb = 4'b0000;
    endcase
  end

  assign ld_byte = dm_rdata[{dm_addr[1:0], 3'b000} +: 8];
  assign ld_half = dm_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dm_rdata;
    endcase
  end

  always_comb begin
    pc_d     = pc_plus4;
    rf_we    = 1'b0;
    rf_wdata = alu_y;
    dm_we    = 1'b0;
    case (opcode)
      OPC_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
      OPC_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
      OPC_JAL: begin
        rf_we    = 1'b1;
        rf_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      OPC_JALR: begin
        rf_we    = 1'b1;
        rf_wdata = pc_plus4;
        pc_d     = (rs1_v + imm_i) & ~32'd1;
      end
      OPC_BRANCH: if (br_take) pc_d = pc_q + imm_b;
      OPC_LOAD:   begin rf_we = 1'b1; rf_wdata = ld_data; end
      OPC_STORE:  dm_we = 1'b1;
      OPC_OPIMM, OPC_OP: begin rf_we = 1'b1; rf_wdata = alu_y; end
      default: ;
    endcase
    if (rd == 5'd0) rf_we = 1'b0;
  end

  // Memory writes are gated by reset so an edge seen during reset writes nothing.
  assign rom_we = dm_we && run && sys_rst_n && (dm_addr[31:28] == 4'h0);
  assign ram_we = dm_we && run && sys_rst_n && (dm_addr[31:28] == 4'h1);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (run) begin
      pc_q <= pc_d;
      if (rf_we) regs_q[rd] <= rf_wdata;
    end
  end

  if (1) begin : u_rom
    logic [31:0] _rom [0:ROM_DEPTH-1];
    assign rom_fetch = _rom[pc_q[ROM_AW+1:2]];
    assign rom_rdata = _rom[dm_addr[ROM_AW+1:2]];
    always_ff @(posedge clk) begin
      if (rom_we) begin
        for (int b = 0; b < 4; b++)
          if (dm_strb[b]) _rom[dm_addr[ROM_AW+1:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
  end

  if (1) begin : u_ram
    logic [31:0] _ram [0:RAM_DEPTH-1];
    assign ram_rdata = _ram[dm_addr[RAM_AW+1:2]];
    always_ff @(posedge clk) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (dm_strb[b]) _ram[dm_addr[RAM_AW+1:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
  end

  // Address bits above the memory index alias by design.
  logic unused_ok;
  assign unused_ok = &{1'b0, pc_q, dm_addr};

endmodule

// File: tb/tb_riscv_soc_top.sv
// tb/tb_riscv_soc_top.sv - directed vector bench for riscv_soc_top

module tb_riscv_soc_top;

  logic clk;
  logic sys_rst_n;
  logic uart_debug_pin;

  riscv_soc_top #(.ROM_DEPTH(4096), .RAM_DEPTH(4096)) dut (
    .clk            (clk),
    .sys_rst_n      (sys_rst_n),
    .uart_debug_pin (uart_debug_pin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_bad;

  typedef struct {
    string       name;
    logic [31:0] i0, i1, i2, i3;
    int          ncyc;
    int          rd;     // negative: compare PC instead of a register
    logic [31:0] ram0;
    logic [31:0] expv;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] enc_i(input int opc, input int rd, input int f3, input int rs1, input int imm);
    logic [31:0] o, r, f, s, m;
    o = opc; r = rd; f = f3; s = rs1; m = imm;
    return {m[11:0], s[4:0], f[2:0], r[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] a, b, c, f, r;
    a = f7; b = rs2; c = rs1; f = f3; r = rd;
    return {a[6:0], b[4:0], c[4:0], f[2:0], r[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int f3, input int rs2, input int rs1, input int imm);
    logic [31:0] f, b, c, m;
    f = f3; b = rs2; c = rs1; m = imm;
    return {m[11:5], b[4:0], c[4:0], f[2:0], m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] f, b, c, m;
    f = f3; b = rs2; c = rs1; m = imm;
    return {m[12], m[10:5], b[4:0], c[4:0], f[2:0], m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input int opc, input int rd, input int imm20);
    logic [31:0] o, r, m;
    o = opc; r = rd; m = imm20;
    return {m[19:0], r[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] r, m;
    r = rd; m = imm;
    return {m[20], m[10:1], m[11], m[19:12], r[4:0], 7'h6f};
  endfunction

  task automatic add_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input int ncyc,
                         input int rd, input logic [31:0] ram0, input logic [31:0] expv);
    vec_t v;
    v.name = nm; v.i0 = a; v.i1 = b; v.i2 = c; v.i3 = d;
    v.ncyc = ncyc; v.rd = rd; v.ram0 = ram0; v.expv = expv;
    vq.push_back(v);
  endtask

  // Called at a falling edge: asserts reset, stops the core and loads memories.
  task automatic hold_reset(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] d, input logic [31:0] ram0);
    sys_rst_n      = 1'b0;
    uart_debug_pin = 1'b0;
    for (int k = 0; k < 16; k++) dut.u_rom._rom[k] = 32'h0;
    for (int k = 1; k < 8; k++) dut.u_ram._ram[k] = 32'hA5A5_0000 + k;
    dut.u_ram._ram[0] = ram0;
    dut.u_rom._rom[0] = a;
    dut.u_rom._rom[1] = b;
    dut.u_rom._rom[2] = c;
    dut.u_rom._rom[3] = d;
  endtask

  task automatic release_reset(input logic run);
    @(negedge clk);
    sys_rst_n      = 1'b1;
    uart_debug_pin = run;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] lui5;
    n_vec = 0;
    n_bad = 0;
    sys_rst_n      = 1'b0;
    uart_debug_pin = 1'b0;
    lui5 = enc_u(7'h37, 5, 32'h10000);
    @(negedge clk);

    check("reset_pc", dut.pc_q, 32'h0);
    check("reset_x1", dut.regs_q[1], 32'h0);

    add_vec("add_x2", enc_i(7'h13,1,0,0,5), enc_i(7'h13,2,0,1,-7), enc_r(0,2,1,0,3), 0, 3, 2, 0, 32'hFFFF_FFFE);
    add_vec("sub", enc_i(7'h13,1,0,0,5), enc_i(7'h13,2,0,0,7), enc_r(32,2,1,0,3), 0, 3, 3, 0, 32'hFFFF_FFFE);
    add_vec("slt", enc_i(7'h13,1,0,0,-1), enc_i(7'h13,2,0,0,1), enc_r(0,2,1,2,3), 0, 3, 3, 0, 32'h1);
    add_vec("sltu", enc_i(7'h13,1,0,0,-1), enc_i(7'h13,2,0,0,1), enc_r(0,2,1,3,3), 0, 3, 3, 0, 32'h0);
    add_vec("srai", enc_u(7'h37,1,32'h80000), enc_i(7'h13,3,5,1,32'h404), 0, 0, 2, 3, 0, 32'hF800_0000);
    add_vec("srli", enc_u(7'h37,1,32'h80000), enc_i(7'h13,3,5,1,4), 0, 0, 2, 3, 0, 32'h0800_0000);
    add_vec("sll_shamt5", enc_i(7'h13,1,0,0,1), enc_i(7'h13,2,0,0,33), enc_r(0,2,1,1,3), 0, 3, 3, 0, 32'h2);
    add_vec("xori", enc_i(7'h13,1,0,0,32'hF0), enc_i(7'h13,3,4,1,-1), 0, 0, 2, 3, 0, 32'hFFFF_FF0F);
    add_vec("ori", enc_i(7'h13,1,0,0,32'h5A), enc_i(7'h13,3,6,1,32'hF0), 0, 0, 2, 3, 0, 32'hFA);
    add_vec("auipc", 32'h0, enc_u(7'h17,3,1), 0, 0, 2, 3, 0, 32'h1004);
    add_vec("x0_ignored", enc_u(7'h37,0,32'h12345), enc_i(7'h13,3,0,0,7), 0, 0, 2, 3, 0, 32'h7);
    add_vec("sltiu", enc_i(7'h13,3,3,0,1), 0, 0, 0, 1, 3, 0, 32'h1);
    add_vec("lb", lui5, enc_i(7'h03,3,0,5,1), 0, 0, 2, 3, 32'h1122_8044, 32'hFFFF_FF80);
    add_vec("lbu", lui5, enc_i(7'h03,3,4,5,1), 0, 0, 2, 3, 32'h1122_8044, 32'h0000_0080);
    add_vec("lh_hi", lui5, enc_i(7'h03,3,1,5,2), 0, 0, 2, 3, 32'h1122_3344, 32'h0000_1122);
    add_vec("lh_neg", lui5, enc_i(7'h03,3,1,5,0), 0, 0, 2, 3, 32'h1122_F344, 32'hFFFF_F344);
    add_vec("lhu", lui5, enc_i(7'h03,3,5,5,0), 0, 0, 2, 3, 32'h1122_F344, 32'h0000_F344);
    add_vec("lw", lui5, enc_i(7'h03,3,2,5,0), 0, 0, 2, 3, 32'h1122_F344, 32'h1122_F344);
    add_vec("sb_then_lw", lui5, enc_i(7'h13,6,0,0,32'h80), enc_s(0,6,5,1), enc_i(7'h03,3,2,5,0), 4, 3, 32'h1122_3344, 32'h1122_8044);
    add_vec("sh_then_lw", lui5, enc_i(7'h13,6,0,0,32'h80), enc_s(1,6,5,2), enc_i(7'h03,3,2,5,0), 4, 3, 32'h1122_3344, 32'h0080_3344);
    add_vec("unmapped_lw", enc_i(7'h13,3,0,0,5), enc_u(7'h37,5,32'h20000), enc_i(7'h03,3,2,5,0), 0, 3, 3, 0, 32'h0);
    add_vec("blt_taken", enc_i(7'h13,1,0,0,-1), enc_b(4,1,0,8), 0, 0, 2, -1, 0, 32'hC);
    add_vec("bltu_not", enc_i(7'h13,1,0,0,-1), enc_b(6,1,0,8), 0, 0, 2, -1, 0, 32'h8);
    add_vec("bge_taken", enc_i(7'h13,1,0,0,-1), enc_b(5,0,1,12), 0, 0, 2, -1, 0, 32'h10);
    add_vec("bgeu_not", enc_i(7'h13,1,0,0,-1), enc_b(7,0,1,12), 0, 0, 2, -1, 0, 32'h8);
    add_vec("jalr_pc", enc_i(7'h13,2,0,0,32'h41), enc_i(7'h67,1,0,2,0), 0, 0, 2, -1, 0, 32'h40);
    add_vec("jalr_link", enc_i(7'h13,2,0,0,32'h41), enc_i(7'h67,1,0,2,0), 0, 0, 2, 1, 0, 32'h8);

    foreach (vq[i]) begin
      hold_reset(vq[i].i0, vq[i].i1, vq[i].i2, vq[i].i3, vq[i].ram0);
      release_reset(1'b1);
      cycles(vq[i].ncyc);
      if (vq[i].rd < 0) got = dut.pc_q;
      else              got = dut.regs_q[vq[i].rd[4:0]];
      check(vq[i].name, got, vq[i].expv);
    end

    // Basic arithmetic program, all three results.
    hold_reset(enc_i(7'h13,1,0,0,5), enc_i(7'h13,2,0,1,-7), enc_r(0,2,1,0,3), 0, 0);
    release_reset(1'b1);
    cycles(3);
    check("prog_x1", dut.regs_q[1], 32'h5);
    check("prog_x2", dut.regs_q[2], 32'hFFFF_FFFE);
    check("prog_x3", dut.regs_q[3], 32'h3);

    // Completion flag store touches only _ram[4].
    hold_reset(lui5, enc_i(7'h13,6,0,0,1), enc_s(2,6,5,16), 0, 32'hA5A5_0000);
    release_reset(1'b1);
    cycles(3);
    for (int k = 0; k < 8; k++)
      check($sformatf("ram_word_%0d", k), dut.u_ram._ram[k], (k == 4) ? 32'h1 : 32'hA5A5_0000 + k);

    // Taken backward branch loops to PC 0.
    hold_reset(enc_i(7'h13,1,0,1,1), 0, enc_b(0,0,0,-8), 0, 0);
    release_reset(1'b1);
    cycles(3);
    check("beq_back_pc", dut.pc_q, 32'h0);
    cycles(3);
    check("beq_loop_pc", dut.pc_q, 32'h0);
    check("beq_loop_x1", dut.regs_q[1], 32'h2);

    hold_reset(0, 0, enc_b(1,0,0,-8), 0, 0);
    release_reset(1'b1);
    cycles(3);
    check("bne_not_pc", dut.pc_q, 32'hC);

    // JAL from 0x20.
    hold_reset(0, 0, 0, 0, 0);
    dut.u_rom._rom[8] = enc_j(1, 16);
    release_reset(1'b1);
    cycles(9);
    check("jal_pc", dut.pc_q, 32'h30);
    check("jal_link", dut.regs_q[1], 32'h24);

    // Run enable low holds everything.
    hold_reset(enc_i(7'h13,7,0,0,1), 0, 0, 0, 0);
    release_reset(1'b0);
    cycles(10);
    check("hold_pc", dut.pc_q, 32'h0);
    check("hold_x7", dut.regs_q[7], 32'h0);
    uart_debug_pin = 1'b1;
    cycles(1);
    check("run_x7", dut.regs_q[7], 32'h1);
    check("run_pc", dut.pc_q, 32'h4);

    // Asynchronous reset mid-program.
    hold_reset(lui5, enc_i(7'h13,6,0,0,9), enc_s(2,6,5,0), enc_i(7'h13,7,0,0,3), 0);
    release_reset(1'b1);
    cycles(4);
    check("pre_rst_ram0", dut.u_ram._ram[0], 32'h9);
    check("pre_rst_pc", dut.pc_q, 32'h10);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_pc", dut.pc_q, 32'h0);
    check("async_rst_x5", dut.regs_q[5], 32'h0);
    check("async_rst_x7", dut.regs_q[7], 32'h0);
    @(negedge clk);
    check("in_rst_pc", dut.pc_q, 32'h0);
    check("rst_keeps_ram0", dut.u_ram._ram[0], 32'h9);
    dut.u_ram._ram[0] = 32'h0;
    sys_rst_n = 1'b1;
    cycles(4);
    check("restart_ram0", dut.u_ram._ram[0], 32'h9);
    check("restart_x7", dut.regs_q[7], 32'h3);
    check("restart_pc", dut.pc_q, 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
